// File: rtl/test_src_pkg.sv
// Shared types and helpers for the multi-channel
// random-delay val/rdy test source.
package test_src_pkg;

  typedef enum logic [1:0] {
    DLY_NONE  = 2'd0,
    DLY_FIXED = 2'd1,
    DLY_RAND  = 2'd2,
    DLY_RSVD  = 2'd3
  } delay_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } src_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] lfsr
  );
    if (lfsr[0])
      return (lfsr >> 1) ^ LFSR_TAPS;
    return lfsr >> 1;
  endfunction

  // Modulus is widened so max_delay of all ones yields lfsr itself.
  function automatic logic [31:0] draw_delay(
    input logic [1:0]  mode,
    input logic [31:0] max_d,
    input logic [31:0] lfsr
  );
    logic [32:0] w_mod;
    logic [32:0] w_rem;
    w_mod = {1'b0, max_d} + 33'd1;
    w_rem = {1'b0, lfsr} % w_mod;
    unique case (delay_mode_e'(mode))
      DLY_FIXED: return max_d;
      DLY_RAND:  return w_rem[31:0];
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/test_rand_delay_source_chan.sv
// One source channel: message array, IDLE/WAIT/DONE FSM,
// gap counter and private LFSR.
module test_rand_delay_source_chan
  import test_src_pkg::*;
#(
  parameter int          p_msg_nbits = 8,
  parameter int          p_num_msgs  = 1024,
  parameter logic [31:0] p_seed      = 32'h1,
  localparam int         NB = $clog2(p_num_msgs + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            max_delay,
  input  logic [1:0]             delay_mode,
  input  logic [NB-1:0]          num_msgs,
  output logic                   val,
  input  logic                   rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done
);

  localparam int AW =
    (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam logic [31:0] SEED =
    (p_seed == 32'd0) ? 32'd1 : p_seed;
  localparam logic [NB-1:0] NMAX = NB'(p_num_msgs);

  logic [p_msg_nbits-1:0] m [p_num_msgs];

  src_state_e  r_state;
  logic [NB-1:0] r_idx;
  logic [31:0] r_cnt;
  logic [31:0] r_lfsr;

  logic [31:0]   w_draw;
  logic [NB-1:0] w_nlim;
  logic [NB:0]   w_next_idx;
  logic          w_last;
  logic          w_val;
  logic          w_fire;
  logic [AW-1:0] w_addr;

  assign w_draw = draw_delay(delay_mode, max_delay, r_lfsr);
  assign w_nlim = (num_msgs > NMAX) ? NMAX : num_msgs;
  assign w_next_idx = {1'b0, r_idx} + (NB+1)'(1);
  // A live num_msgs drop below idx+1 ends the stream here too.
  assign w_last = w_next_idx >= {1'b0, w_nlim};
  assign w_val  = (r_state == WAIT) && (r_cnt == 32'd0);
  assign w_fire = w_val && rdy;
  assign w_addr = r_idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_lfsr  <= SEED;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_nlim == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt   <= w_draw;
            r_lfsr  <= lfsr_next(r_lfsr);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_fire) begin
            if (w_last) begin
              r_state <= DONE;
            end else begin
              r_idx  <= r_idx + NB'(1);
              r_cnt  <= w_draw;
              r_lfsr <= lfsr_next(r_lfsr);
            end
          end else if (r_cnt != 32'd0) begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: r_state <= DONE;
      endcase
    end
  end

  // Outputs are forced quiet in the reset cycle itself.
  assign val  = !reset && w_val;
  assign done = !reset && (r_state == DONE);
  assign msg  = (!reset && r_state == WAIT) ? m[w_addr]
                                             : '0;

endmodule

// File: rtl/test_multi_rand_delay_source.sv
// Multi-channel val/rdy test source with per-channel
// none/fixed/random inter-message gaps.
module test_multi_rand_delay_source
  import test_src_pkg::*;
#(
  parameter int          p_nchannels = 2,
  parameter int          p_msg_nbits = 8,
  parameter int          p_num_msgs  = 1024,
  parameter logic [31:0] p_seed      = 32'hC2C2_0001,
  localparam int         NB = $clog2(p_num_msgs + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [32*p_nchannels-1:0]          max_delay,
  input  logic [2*p_nchannels-1:0]           delay_mode,
  input  logic [NB*p_nchannels-1:0]          num_msgs,
  output logic [p_nchannels-1:0]             val,
  input  logic [p_nchannels-1:0]             rdy,
  output logic [p_msg_nbits*p_nchannels-1:0] msg,
  output logic [p_nchannels-1:0]             done,
  output logic                               all_done
);

  for (genvar c = 0; c < p_nchannels; c++) begin : g_chan
    test_rand_delay_source_chan #(
      .p_msg_nbits (p_msg_nbits),
      .p_num_msgs  (p_num_msgs),
      .p_seed      (p_seed ^ 32'(c))
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .max_delay  (max_delay[32*c +: 32]),
      .delay_mode (delay_mode[2*c +: 2]),
      .num_msgs   (num_msgs[NB*c +: NB]),
      .val        (val[c]),
      .rdy        (rdy[c]),
      .msg        (msg[p_msg_nbits*c +: p_msg_nbits]),
      .done       (done[c])
    );
  end

  assign all_done = &done;

endmodule

// File: tb/tb_test_multi_rand_delay_source.sv
// Directed bench for the multi-channel delay source
// (two channels, 8-bit messages).
module tb_test_multi_rand_delay_source;

  localparam int NB = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] max_delay = '0;
  logic [3:0]  delay_mode = '0;
  logic [21:0] num_msgs = '0;
  logic [1:0]  val;
  logic [1:0]  rdy = '0;
  logic [15:0] msg;
  logic [1:0]  done;
  logic        all_done;

  int vecs = 0;
  int errs = 0;

  logic [7:0] m0 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] m1 [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
  int fr [2][2][6];

  test_multi_rand_delay_source dut (
    .clk        (clk),
    .reset      (reset),
    .max_delay  (max_delay),
    .delay_mode (delay_mode),
    .num_msgs   (num_msgs),
    .val        (val),
    .rdy        (rdy),
    .msg        (msg),
    .done       (done),
    .all_done   (all_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_reset();
    reset = 1'b1;
  endtask

  // Leaves the bench inside cycle 0 (first cycle with reset low).
  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic [1:0] mode,
                     input logic [31:0] maxd, input int n);
    delay_mode[ch*2 +: 2] = mode;
    max_delay[ch*32 +: 32] = maxd;
    num_msgs[ch*NB +: NB] = NB'(n);
  endtask

  function automatic logic [31:0] ref_lfsr(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
  endfunction

  task automatic test_reset();
    start_reset();
    step();
    vecs++;
    if (val !== 2'b00 || done !== 2'b00 || msg !== 16'h0
        || all_done !== 1'b0) begin
      errs++;
      $display("FAIL reset: val=%b done=%b msg=%h all=%b want 0",
               val, done, msg, all_done);
    end
  endtask

  task automatic test_mode0();
    start_reset();
    cfg(0, 2'd0, 0, 4);
    cfg(1, 2'd0, 0, 0);
    rdy = 2'b11;
    release_reset();
    vecs++;
    if (val[0] !== 1'b0) begin
      errs++;
      $display("FAIL mode0_c0: val=%b want 0", val[0]);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      vecs++;
      if (k <= 4) begin
        if (val[0] !== 1'b1 || msg[7:0] !== m0[k-1]) begin
          errs++;
          $display("FAIL mode0_c%0d: val=%b msg=%h want 1 %h",
                   k, val[0], msg[7:0], m0[k-1]);
        end
      end else if (val[0] !== 1'b0 || done[0] !== 1'b1
                   || all_done !== 1'b1) begin
        errs++;
        $display("FAIL mode0_done: val=%b done=%b all=%b want 0 1 1",
                 val[0], done[0], all_done);
      end
    end
  endtask

  task automatic test_fixed();
    logic ev;
    start_reset();
    cfg(0, 2'd1, 3, 2);
    cfg(1, 2'd0, 0, 0);
    rdy = 2'b11;
    release_reset();
    for (int k = 1; k <= 9; k++) begin
      step();
      ev = (k == 4 || k == 8);
      vecs++;
      if (val[0] !== ev || done[0] !== (k == 9)) begin
        errs++;
        $display("FAIL fixed_c%0d: val=%b done=%b want %b %b",
                 k, val[0], done[0], ev, (k == 9));
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] em;
    start_reset();
    cfg(0, 2'd0, 0, 4);
    cfg(1, 2'd0, 0, 0);
    rdy = 2'b00;
    release_reset();
    for (int k = 1; k <= 7; k++) begin
      step();
      rdy[0] = (k >= 6);
      em = (k <= 6) ? m0[0] : m0[1];
      vecs++;
      if (val[0] !== 1'b1 || msg[7:0] !== em) begin
        errs++;
        $display("FAIL stall_c%0d: val=%b msg=%h want 1 %h",
                 k, val[0], msg[7:0], em);
      end
    end
  endtask

  task automatic run_rand(input int r);
    int nf [2];
    start_reset();
    cfg(0, 2'd2, 7, 6);
    cfg(1, 2'd2, 7, 6);
    rdy = 2'b11;
    release_reset();
    nf[0] = 0;
    nf[1] = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      for (int c = 0; c < 2; c++)
        if (val[c] === 1'b1 && nf[c] < 6) begin
          fr[r][c][nf[c]] = k;
          nf[c]++;
        end
    end
    for (int c = 0; c < 2; c++) begin
      vecs++;
      if (nf[c] != 6) begin
        errs++;
        $display("FAIL rand_count r%0d ch%0d: got %0d want 6",
                 r, c, nf[c]);
      end
    end
  endtask

  task automatic test_rand();
    logic [31:0] l;
    int t;
    int ex;
    bit same;
    run_rand(0);
    run_rand(1);
    for (int c = 0; c < 2; c++) begin
      l = 32'hC2C2_0001 ^ 32'(c);
      t = 0;
      for (int i = 0; i < 6; i++) begin
        t = t + 1 + int'(l % 32'd8);
        l = ref_lfsr(l);
        ex = t;
        vecs++;
        if (fr[0][c][i] != ex || fr[1][c][i] != ex) begin
          errs++;
          $display("FAIL rand ch%0d msg%0d: cyc %0d/%0d want %0d",
                   c, i, fr[0][c][i], fr[1][c][i], ex);
        end
      end
    end
    same = 1'b1;
    for (int i = 0; i < 6; i++)
      if (fr[0][0][i] != fr[0][1][i]) same = 1'b0;
    vecs++;
    if (same) begin
      errs++;
      $display("FAIL rand_distinct: ch0 and ch1 traces equal, want differ");
    end
  endtask

  task automatic test_two_chan();
    start_reset();
    cfg(0, 2'd0, 0, 3);
    cfg(1, 2'd1, 5, 1);
    rdy = 2'b11;
    release_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
      vecs++;
      if (done[0] !== (k >= 4) || done[1] !== (k >= 7)
          || all_done !== (k >= 7) || val[1] !== (k == 6)) begin
        errs++;
        $display("FAIL two_c%0d: done=%b all=%b val1=%b want %b%b %b %b",
                 k, done, all_done, val[1], (k >= 7), (k >= 4),
                 (k >= 7), (k == 6));
      end
    end
    vecs++;
    if (msg[15:8] !== 8'h00) begin
      errs++;
      $display("FAIL two_msg1_done: msg=%h want 00", msg[15:8]);
    end
  endtask

  task automatic test_zero_and_midreset();
    start_reset();
    cfg(0, 2'd0, 0, 0);
    cfg(1, 2'd0, 0, 0);
    rdy = 2'b11;
    release_reset();
    for (int k = 1; k <= 4; k++) begin
      step();
      vecs++;
      if (done[0] !== 1'b1 || val[0] !== 1'b0) begin
        errs++;
        $display("FAIL zero_c%0d: done=%b val=%b want 1 0",
                 k, done[0], val[0]);
      end
    end
    start_reset();
    cfg(0, 2'd0, 0, 4);
    release_reset();
    for (int k = 1; k <= 2; k++) begin
      step();
      vecs++;
      if (val[0] !== 1'b1 || msg[7:0] !== m0[k-1]) begin
        errs++;
        $display("FAIL mid_pre_c%0d: val=%b msg=%h want 1 %h",
                 k, val[0], msg[7:0], m0[k-1]);
      end
    end
    step();
    reset = 1'b1;
    #1;
    vecs++;
    if (val[0] !== 1'b0 || msg[7:0] !== 8'h00) begin
      errs++;
      $display("FAIL mid_reset: val=%b msg=%h want 0 00",
               val[0], msg[7:0]);
    end
    release_reset();
    for (int k = 1; k <= 2; k++) begin
      step();
      vecs++;
      if (val[0] !== 1'b1 || msg[7:0] !== m0[k-1]) begin
        errs++;
        $display("FAIL mid_post_c%0d: val=%b msg=%h want 1 %h",
                 k, val[0], msg[7:0], m0[k-1]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      dut.g_chan[0].u_chan.m[i] = m0[i];
      dut.g_chan[1].u_chan.m[i] = m1[i];
    end
    test_reset();
    test_mode0();
    test_fixed();
    test_stall();
    test_rand();
    test_two_chan();
    test_zero_and_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
